// File: rtl/modn_counter.sv
//==============================================================================
// Module      : modn_counter
// Description : Free-running modulo-N up-counter (0..N-1). Optional macro
//               MODN_TC_EN adds a registered terminal-count output tc.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module modn_counter #(
    parameter int N     = 11,
    parameter int WIDTH = 11
) (
    input  logic             Clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Count
`ifdef MODN_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(N - 1);

    generate
        if ((N < 2) || (N > (2 ** WIDTH))) begin : g_bad_param
            $error("modn_counter: N must satisfy 2 <= N <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    // The >= compare handles both the normal wrap and any out-of-range state.
    always_comb begin
        w_count_d = r_count_q + WIDTH'(1);
        if (r_count_q >= C_LAST) begin
            w_count_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign Count = r_count_q;

`ifdef MODN_TC_EN
    logic r_tc_q;
    logic w_tc_d;

    // Decoded from the next count so tc lines up with Count == N-1.
    always_comb begin
        w_tc_d = (w_count_d == C_LAST);
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            r_tc_q <= 1'b0;
        end else begin
            r_tc_q <= w_tc_d;
        end
    end

    assign tc = r_tc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_modn_counter.sv
//==============================================================================
// Module      : tb_modn_counter
// Description : Self-checking bench for modn_counter at N=11, N=2 and N=2048.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_modn_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] c11;
    logic [0:0]  c2;
    logic [10:0] c2048;
`ifdef MODN_TC_EN
    logic        tc11;
    logic        tc2;
    logic        tc2048;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    modn_counter #(.N(11), .WIDTH(11)) u_n11 (
        .Clk(clk), .rst(rst), .Count(c11)
`ifdef MODN_TC_EN
        , .tc(tc11)
`endif
    );

    modn_counter #(.N(2), .WIDTH(1)) u_n2 (
        .Clk(clk), .rst(rst), .Count(c2)
`ifdef MODN_TC_EN
        , .tc(tc2)
`endif
    );

    modn_counter #(.N(2048), .WIDTH(11)) u_n2048 (
        .Clk(clk), .rst(rst), .Count(c2048)
`ifdef MODN_TC_EN
        , .tc(tc2048)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: edges since last reset; every counter must equal that edge count mod N.
    int  k     = 0;
    bit  valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            k     = 0;
            valid = 1'b1;
        end else if (valid) begin
            k = k + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_n11",   64'(c11),   64'(k % 11));
            check("model_n2",    64'(c2),    64'(k % 2));
            check("model_n2048", 64'(c2048), 64'(k % 2048));
`ifdef MODN_TC_EN
            check("model_tc11",   64'(tc11),   64'((k % 11) == 10));
            check("model_tc2",    64'(tc2),    64'((k % 2) == 1));
            check("model_tc2048", 64'(tc2048), 64'((k % 2048) == 2047));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int tbl11 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 1};
    int tbl2  [6]  = '{1, 0, 1, 0, 1, 0};

    initial begin
        // Reset held for two edges.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_n11", 64'(c11), 64'd0);
            check("rst_n2", 64'(c2), 64'd0);
            check("rst_n2048", 64'(c2048), 64'd0);
`ifdef MODN_TC_EN
            check("rst_tc11", 64'(tc11), 64'd0);
`endif
        end
        rst = 1'b0;

        // First 12 edges after release, hand-computed.
        for (int i = 0; i < 12; i++) begin
            step();
            check("seq_n11", 64'(c11), 64'(tbl11[i]));
            if (i < 6) check("seq_n2", 64'(c2), 64'(tbl2[i]));
`ifdef MODN_TC_EN
            check("seq_tc11", 64'(tc11), 64'(tbl11[i] == 10));
`endif
        end

        // Continue to 45 edges total after release (45 mod 11 = 1).
        for (int i = 12; i < 45; i++) step();
        check("long_n11", 64'(c11), 64'd1);

        // Advance to 7, then reset mid-sequence for three edges.
        for (int i = 0; i < 6; i++) step();
        check("pre_mid_n11", 64'(c11), 64'd7);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_n11", 64'(c11), 64'd0);
        end
        rst = 1'b0;
        step();
        check("post_mid_n11", 64'(c11), 64'd1);

        // Advance to N-1 = 10, then reset there.
        for (int i = 0; i < 9; i++) step();
        check("pre_last_n11", 64'(c11), 64'd10);
`ifdef MODN_TC_EN
        check("pre_last_tc11", 64'(tc11), 64'd1);
`endif
        rst = 1'b1;
        step();
        check("last_rst_n11", 64'(c11), 64'd0);
`ifdef MODN_TC_EN
        check("last_rst_tc11", 64'(tc11), 64'd0);
`endif
        rst = 1'b0;

        // Full period of the N=2048 instance, wrapping through natural overflow.
        for (int i = 0; i < 2047; i++) step();
        check("top_n2048", 64'(c2048), 64'd2047);
`ifdef MODN_TC_EN
        check("top_tc2048", 64'(tc2048), 64'd1);
`endif
        step();
        check("wrap_n2048", 64'(c2048), 64'd0);
`ifdef MODN_TC_EN
        check("wrap_tc2048", 64'(tc2048), 64'd0);
`endif
        step();
        check("after_wrap_n2048", 64'(c2048), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
